// File: rtl/add64_pkg.sv
// Shared types and constants for the multi-cycle 64-bit adder.
package add64_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add64_state_t;

  function automatic int nchunks(input int chunk_w);
    return WORD_W / chunk_w;
  endfunction

endpackage

// File: rtl/add64seq_add_chunk.sv
// Combinational CHUNK_W-bit ripple-carry adder built from full-adder cells.
module add_chunk #(
  parameter int CHUNK_W = 16
) (
  output logic [CHUNK_W-1:0] sum,
  output logic               cout,
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               cin
);

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] f_fa(input logic xi, input logic yi, input logic ci);
    return {(xi & yi) | (ci & (xi ^ yi)), xi ^ yi ^ ci};
  endfunction

  always_comb begin
    logic [1:0] w_cell;
    logic       w_c;
    sum    = '0;
    w_c    = cin;
    w_cell = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      w_cell = f_fa(x[i], y[i], w_c);
      sum[i] = w_cell[0];
      w_c    = w_cell[1];
    end
    cout = w_c;
  end

endmodule

// File: rtl/add64seq.sv
// Multi-cycle 64-bit signed adder, CHUNK_W bits per cycle with a registered carry.
// Define ADD64SEQ_CC_EN to build the registered cf/zf/sf condition codes.
module add64seq
  import add64_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WORD_W-1:0] a,
  input  logic signed [WORD_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WORD_W-1:0] s,
  output logic                     of,
  output logic                     cf,
  output logic                     zf,
  output logic                     sf
);

  localparam int N     = nchunks(CHUNK_W);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if ((WORD_W % CHUNK_W) != 0) begin : g_chunk_chk
    $error("add64seq: CHUNK_W must divide 64");
  end

  function automatic logic f_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  add64_state_t              r_state;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic signed [WORD_W-1:0]  r_a;
  logic signed [WORD_W-1:0]  r_b;
  logic signed [WORD_W-1:0]  r_s;
  logic                      r_of;
  logic                      r_carry;
  logic [IDX_W-1:0]          r_idx;

  logic                      w_accept;
  logic                      w_last;
  logic [6:0]                w_base;
  logic [CHUNK_W-1:0]        w_a_chunk;
  logic [CHUNK_W-1:0]        w_b_chunk;
  logic [CHUNK_W-1:0]        w_sum;
  logic                      w_cout;
  logic signed [WORD_W-1:0]  w_s_next;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_state == RUN) && (r_idx == LAST);
  assign w_base    = 7'(r_idx) * 7'(CHUNK_W);
  assign w_a_chunk = r_a[w_base +: CHUNK_W];
  assign w_b_chunk = r_b[w_base +: CHUNK_W];

  add_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .sum  (w_sum),
    .cout (w_cout),
    .x    (w_a_chunk),
    .y    (w_b_chunk),
    .cin  (r_carry)
  );

  // Sum word with the current chunk merged in; flags are taken from it on the last chunk.
  always_comb begin
    w_s_next                     = r_s;
    w_s_next[w_base +: CHUNK_W]  = w_sum;
  end

  // Operands are data only: captured at the accept edge, never reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_of        <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_s        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_s     <= w_s_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_of        <= f_ovf(r_a[WORD_W-1], r_b[WORD_W-1], w_s_next[WORD_W-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ADD64SEQ_CC_EN
  logic r_cf;
  logic r_zf;
  logic r_sf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cf <= 1'b0;
      r_zf <= 1'b0;
      r_sf <= 1'b0;
    end else if (w_last) begin
      r_cf <= w_cout;
      r_zf <= ~|w_s_next;
      r_sf <= w_s_next[WORD_W-1];
    end
  end

  assign cf = r_cf;
  assign zf = r_zf;
  assign sf = r_sf;
`else
  assign cf = 1'b0;
  assign zf = 1'b0;
  assign sf = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign of        = r_of;

endmodule

// File: tb/tb_add64seq.sv
// Self-checking bench for add64seq: directed vector table, handshake corner cases, random ops.
module tb_add64seq;

  localparam int CW  = 16;
  localparam int NCH = 64 / CW;

`ifdef ADD64SEQ_CC_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  localparam logic signed [65:0] MAXV = 66'sd9223372036854775807;
  localparam logic signed [65:0] MINV = -66'sd9223372036854775808;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, out_valid, out_ready;
  logic signed [63:0] a, b, s;
  logic               of, cf, zf, sf;

  int total = 0;
  int bad   = 0;

  add64seq #(.CHUNK_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .of(of), .cf(cf), .zf(zf), .sf(sf)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic        of;
    logic        cf;
    logic        zf;
    logic        sf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: wide signed and unsigned arithmetic, overflow as range violation.
  task automatic model(input logic [63:0] x, input logic [63:0] y, output logic [63:0] es,
                       output logic eof, output logic ecf, output logic ezf, output logic esf);
    logic [64:0]        u;
    logic signed [65:0] w;
    u   = {1'b0, x} + {1'b0, y};
    w   = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
    es  = u[63:0];
    eof = (w > MAXV) || (w < MINV);
    ecf = CC & u[64];
    ezf = CC & (es == 64'd0);
    esf = CC & es[63];
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~x; b = ~y;
    wait_out(lat);
  endtask

  task automatic check_result(input string tag, input logic [63:0] es, input logic eof,
                              input logic ecf, input logic ezf, input logic esf);
    check({tag, ".s"},  s, es);
    check({tag, ".of"}, {63'd0, of}, {63'd0, eof});
    check({tag, ".cf"}, {63'd0, cf}, {63'd0, ecf});
    check({tag, ".zf"}, {63'd0, zf}, {63'd0, ezf});
    check({tag, ".sf"}, {63'd0, sf}, {63'd0, esf});
  endtask

  vec_t vec[6];

  initial begin
    int          lat;
    logic [63:0] es, x, y;
    logic        eof, ecf, ezf, esf;
    bit          pulse;

    vec[0] = '{64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[4] = '{64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
               1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.in_ready",  {63'd0, in_ready},  64'd1);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check_result("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed vectors with expected values written out by hand.
    for (int i = 0; i < 6; i++) begin
      run_op(vec[i].a, vec[i].b, lat);
      check($sformatf("vec%0d.lat", i), lat, NCH);
      check_result($sformatf("vec%0d", i), vec[i].s, vec[i].of,
                   vec[i].cf & CC, vec[i].zf & CC, vec[i].sf & CC);
      @(posedge clk); #1;
      check($sformatf("vec%0d.ovld_drop", i), {63'd0, out_valid}, 64'd0);
      check($sformatf("vec%0d.in_ready", i), {63'd0, in_ready}, 64'd1);
    end

    // Backpressure: result held for 3 cycles while a new pair is offered and ignored.
    out_ready = 1'b0;
    run_op(64'd10, 64'd20, lat);
    check("bp.lat", lat, NCH);
    a = 64'd1; b = 64'd1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d.out_valid", k), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d.in_ready", k),  {63'd0, in_ready},  64'd0);
      check_result($sformatf("bp%0d", k), 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.rel.in_ready",  {63'd0, in_ready},  64'd1);
    check("bp.rel.out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    wait_out(lat);
    check("bp2.lat", lat, NCH);
    check("bp2.s", s, 64'd2);
    @(posedge clk); #1;

    // Reset during the second RUN cycle aborts the operation.
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.in_ready",  {63'd0, in_ready},  64'd1);
    check("abort.out_valid", {63'd0, out_valid}, 64'd0);
    check_result("abort", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1'b1;
    end
    check("abort.no_pulse", {63'd0, pulse}, 64'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 5 == 1) y = -x;
      if (i % 7 == 2) x[63:48] = 16'h7FFF;
      model(x, y, es, eof, ecf, ezf, esf);
      run_op(x, y, lat);
      check($sformatf("rnd%0d.lat", i), lat, NCH);
      check_result($sformatf("rnd%0d", i), es, eof, ecf, ezf, esf);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add64seq.md
# add64seq

Multi-cycle 64-bit signed adder for the Y86-64 ALU: the addition counterpart to the existing 64-bit subtractor. It accepts an operand pair through a valid/ready handshake and adds it CHUNK_W bits per cycle with a registered carry. It returns the sum, a signed-overflow flag and, optionally, Y86 condition-code bits through a second valid/ready handshake. The ALU uses it when the add path must be split across cycles to meet timing.

## Interface
- CHUNK_W, 16, bits added per cycle; legal values 8, 16, 32, 64; N = 64/CHUNK_W chunks.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands.
- a  in  64  signed augend.
- b  in  64  signed addend.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer takes the result.
- s  out  64  signed sum a+b, modulo 2^64.
- of  out  1  signed overflow.
- cf  out  1  carry out of bit 63 (condition-code build only).
- zf  out  1  s == 0 (condition-code build only).
- sf  out  1  s[63] (condition-code build only).

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a and b; clear the carry register and chunk index idx; clear s; go to RUN.
- RUN
  - in_ready=0.
  - Each cycle: {c, s[idx*CHUNK_W +: CHUNK_W]} = a_chunk + b_chunk + carry; carry <= c; idx <= idx+1.
  - On idx==N-1: go to DONE and register of, plus cf/zf/sf if built.
- DONE
  - out_valid=1; s and flags held stable.
  - On out_ready: go to IDLE.
  - While out_ready=0: hold every output indefinitely.
- Arithmetic
  - of = (a[63]==b[63]) && (s[63]!=a[63]), using the latched operands.
  - cf = final carry.
  - zf = ~|s.
  - sf = s[63].
- Input handling
  - a and b are sampled only at the accept edge; later changes on the inputs are ignored.
  - in_valid seen in RUN or DONE is not accepted. The producer must hold in_valid and its operands until in_ready.
- Reset
  - Values after rst: state IDLE, in_ready=1, out_valid=0, s=0, of=cf=zf=sf=0, carry=0, idx=0.
  - rst asserted in RUN or DONE aborts the operation. No out_valid is produced for that operand pair.
  - rst has priority over any handshake in the same cycle.

## Timing
- Accept edge E0 → RUN.
- Edges E1..EN each process one chunk. DONE is entered at EN; out_valid is high in the cycle after EN.
- Latency from accept to out_valid: N cycles. With CHUNK_W=16 this is 4; with CHUNK_W=64 it is 1.
- Handshake completes at the edge where out_valid&&out_ready. in_ready rises in the following cycle.
- Minimum initiation interval: N+2 cycles. There is no overlap between operations.
- All outputs are registered. The critical path is a CHUNK_W-bit ripple add plus the carry register.

## Configuration
- ADD64SEQ_CC_EN defined:
  - cf, zf and sf are computed and registered as specified in Operation.
- ADD64SEQ_CC_EN undefined:
  - cf, zf and sf ports remain, tied to 0, with no registers for them.
  - s, of, the handshake and the latency are identical to the defined build.

## Structure
- Package add64_pkg holds:
  - WORD_W = 64.
  - State enum add64_state_t {IDLE, RUN, DONE}.
  - Function nchunks(CHUNK_W) returning WORD_W/CHUNK_W.
- One sub-module, add_chunk: combinational CHUNK_W-bit ripple adder built from full-adder cells.
  - Ports: sum, cout, x, y, cin.
  - Instantiated once in add64seq.
- Elaboration check: fail if CHUNK_W does not divide 64.

## Test plan
- a=5, b=3, CHUNK_W=16, out_ready=1 → out_valid exactly 4 cycles after accept; s=8, of=0, cf=0, zf=0, sf=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1 → s=0x8000_0000_0000_0000, of=1, sf=1, cf=0, zf=0.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1 → s=0, cf=1, zf=1, of=0. Checks carry propagation across every chunk boundary.
- a=b=0x8000_0000_0000_0000 → s=0, of=1, cf=1, zf=1, sf=0. Same vector without ADD64SEQ_CC_EN → cf=zf=sf=0; s and of unchanged.
- Hold out_ready=0 for 3 cycles in DONE → s and flags stable, in_ready=0, and a new in_valid with a=1, b=1 is ignored. Then raise out_ready → in_ready=1 next cycle, and the second pair is accepted and returns s=2.
- Assert rst for 1 cycle at the second RUN cycle → next cycle: IDLE, in_ready=1, s=0, all flags 0, and no out_valid pulse for the aborted pair.
